// File: rtl/aqua_arb_pkg.sv
// Shared types and helpers for the N-channel memory arbiter.
// Optional feature macro used by the arbiter: AQUA_ARB_LOCK_EN.
package aqua_arb_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_t;

  // Arbitration policy selectors for the MODE parameter
  localparam int MODE_TDM = 0;
  localparam int MODE_RR  = 1;

  // Width of a channel index; never below one bit
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/aqua_rr_picker.sv
// Combinational rotate-priority picker: returns the first set request bit
// strictly after ptr, wrapping around. With a one-hot request vector it
// simply reports that bit, which is how the TDM slot owner is selected.
module aqua_rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          valid
);

  logic [IW-1:0] idx;

  // Scan from the farthest offset down so the nearest requester after ptr wins
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(ptr) + k) % N);
      if (req[idx]) begin
        grant = idx;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aqua_mem_arbiter_n.sv
// N-channel arbiter in front of one shared memory port.
// Arbitration is TDM (MODE=0) or round-robin (MODE=1). Each transaction
// walks IDLE -> ISSUE -> WAIT and finishes with a one-cycle chReady pulse.
// Optional macro AQUA_ARB_LOCK_EN adds chLock for atomic multi-access
// sequences: a channel that completes with its lock high keeps exclusive
// ownership until it drops the lock while the arbiter is idle.
module aqua_mem_arbiter_n
  import aqua_arb_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int MEM_DATA_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int MODE           = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_CH*MEM_ADDR_WIDTH-1:0] chAddr,
  input  logic [NUM_CH*MEM_DATA_WIDTH-1:0] chData,
  input  logic [NUM_CH-1:0]                chWr,
  input  logic [NUM_CH-1:0]                chReq,
  output logic [NUM_CH-1:0]                chReady,
  output logic [MEM_DATA_WIDTH-1:0]        memDataOutReg,
  output logic [MEM_ADDR_WIDTH-1:0]        memAddr,
  output logic                             memWr,
  output logic                             memReq,
  output logic [MEM_DATA_WIDTH-1:0]        memDataIn,
  input  logic                             memBusyOut,
  input  logic [MEM_DATA_WIDTH-1:0]        memDataOut
`ifdef AQUA_ARB_LOCK_EN
  ,
  input  logic [NUM_CH-1:0]                chLock
`endif
);

  localparam int            IW       = idx_width(NUM_CH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CH - 1);

  // Per-channel views of the flat request buses
  logic [MEM_ADDR_WIDTH-1:0] addr_arr [NUM_CH];
  logic [MEM_DATA_WIDTH-1:0] data_arr [NUM_CH];

  arb_state_t                state_reg;
  arb_state_t                state_next;
  logic [IW-1:0]             gnt_reg;
  logic [IW-1:0]             rr_ptr_reg;
  logic [IW-1:0]             slot_reg;
  logic [NUM_CH-1:0]         ready_reg;
  logic [MEM_ADDR_WIDTH-1:0] addr_reg;
  logic [MEM_DATA_WIDTH-1:0] wdata_reg;
  logic                      wr_reg;
  logic [MEM_DATA_WIDTH-1:0] rdata_reg;

  logic [NUM_CH-1:0]         slot_mask;
  logic [NUM_CH-1:0]         gnt_onehot;
  logic [NUM_CH-1:0]         lock_mask;
  logic                      lock_hold;
  logic [NUM_CH-1:0]         eligible;
  logic [NUM_CH-1:0]         pick_req;
  logic [IW-1:0]             pick_ptr;
  logic [IW-1:0]             pick_idx;
  logic                      pick_valid;
  logic                      grant_en;
  logic                      done;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
    assign addr_arr[gi]   = chAddr[gi*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
    assign data_arr[gi]   = chData[gi*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
    assign slot_mask[gi]  = (slot_reg == IW'(gi));
    assign gnt_onehot[gi] = (gnt_reg == IW'(gi));
  end

`ifdef AQUA_ARB_LOCK_EN
  logic          lock_active_reg;
  logic [IW-1:0] lock_ch_reg;

  // Lock is effective only while the owner keeps its chLock bit high
  assign lock_hold = lock_active_reg & chLock[lock_ch_reg];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lock
    assign lock_mask[gi] = !lock_hold || (lock_ch_reg == IW'(gi));
  end

  // Lock is taken at completion and released when dropped in IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_active_reg <= 1'b0;
      lock_ch_reg     <= '0;
    end else if (done) begin
      lock_active_reg <= chLock[gnt_reg];
      lock_ch_reg     <= gnt_reg;
    end else if (state_reg == ST_IDLE && !lock_hold) begin
      lock_active_reg <= 1'b0;
    end
  end
`else
  assign lock_hold = 1'b0;
  assign lock_mask = '1;
`endif

  // A channel whose ready pulse is showing is not yet asking again
  assign eligible = chReq & ~ready_reg & lock_mask;
  assign pick_req = (MODE == MODE_TDM) ? (eligible & slot_mask) : eligible;
  assign pick_ptr = (MODE == MODE_TDM) ? slot_reg : rr_ptr_reg;

  aqua_rr_picker #(
    .N  (NUM_CH),
    .IW (IW)
  ) u_picker (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .grant (pick_idx),
    .valid (pick_valid)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state and transaction strobes
  always_comb begin
    state_next = state_reg;
    grant_en   = 1'b0;
    done       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_en   = 1'b1;
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (!memBusyOut) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!memBusyOut) begin
          done       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Latch the granted channel's request fields; held until the next grant
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_reg   <= '0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wr_reg    <= 1'b0;
    end else if (grant_en) begin
      gnt_reg   <= pick_idx;
      addr_reg  <= addr_arr[pick_idx];
      wdata_reg <= data_arr[pick_idx];
      wr_reg    <= chWr[pick_idx];
    end
  end

  // Completion: ready pulse to the owner, read data captured for reads only
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_reg <= '0;
      rdata_reg <= '0;
    end else begin
      ready_reg <= done ? gnt_onehot : '0;
      if (done && !wr_reg) begin
        rdata_reg <= memDataOut;
      end
    end
  end

  // Arbitration bookkeeping: advances only in IDLE and freezes under a lock
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg <= LAST_IDX;
      slot_reg   <= '0;
    end else if (state_reg == ST_IDLE && !lock_hold) begin
      if (MODE == MODE_RR && pick_valid) begin
        rr_ptr_reg <= pick_idx;
      end
      slot_reg <= (slot_reg == LAST_IDX) ? '0 : slot_reg + 1'b1;
    end
  end

  assign memReq        = (state_reg == ST_ISSUE);
  assign memAddr       = addr_reg;
  assign memDataIn     = wdata_reg;
  assign memWr         = wr_reg;
  assign chReady       = ready_reg;
  assign memDataOutReg = rdata_reg;

endmodule
